// File: rtl/sram_phase_scheduler.sv
// Sequencer that runs UART load, IDCT (M2) and colour conversion (M1) in order and owns the SRAM port.
// Optional macro PHASE_PERF_EN adds per-phase 32-bit cycle counters.
module sram_phase_scheduler #(
  parameter int SKIP_UART      = 0,
  parameter int TIMEOUT_CYCLES = 4194304,
  parameter int TO_W           = 23
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] UART_address,
  input  logic [15:0] UART_write_data,
  input  logic        UART_we_n,
  input  logic [17:0] M2_address,
  input  logic [15:0] M2_write_data,
  input  logic        M2_we_n,
  input  logic [17:0] M1_address,
  input  logic [15:0] M1_write_data,
  input  logic        M1_we_n,
  input  logic        UART_done,
  input  logic        M2_done,
  input  logic        M1_done,
  output logic        UART_enable,
  output logic        M2_enable,
  output logic        M1_enable,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [1:0]  Phase
`ifdef PHASE_PERF_EN
  ,
  output logic [31:0] UART_cycles,
  output logic [31:0] M2_cycles,
  output logic [31:0] M1_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_UART, S_GAP1, S_RUN_M2, S_GAP2, S_RUN_M1, S_DONE, S_ERROR
  } state_t;

  state_t r_state, w_next, w_first_run;

  logic [TO_W-1:0] r_to;
  logic [17:0]     r_sram_addr;
  logic [15:0]     r_sram_wd;
  logic            r_sram_we_n;

  logic            w_timeout, w_run, w_hold, w_start_ok;
  logic [17:0]     w_req_addr;
  logic [15:0]     w_req_wd;
  logic            w_req_we_n;
  logic [2:0]      w_act;

  assign w_first_run = (SKIP_UART != 0) ? S_RUN_M2 : S_RUN_UART;
  assign w_timeout   = (r_to == TO_W'(TIMEOUT_CYCLES - 1));
  assign w_start_ok  = Start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign w_act       = {r_state == S_RUN_M1, r_state == S_RUN_M2, r_state == S_RUN_UART};
  assign w_run       = |w_act;
  // Only forward a client request while that client stays active, so the
  // register never carries a write into a GAP, DONE or ERROR cycle.
  assign w_hold      = w_run && (w_next == r_state);

  always_comb begin
    w_next     = r_state;
    w_req_addr = 18'd0;
    w_req_wd   = 16'd0;
    w_req_we_n = 1'b1;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (Start) w_next = w_first_run;
      S_RUN_UART: begin
        w_req_addr = UART_address;
        w_req_wd   = UART_write_data;
        w_req_we_n = UART_we_n;
        if (UART_done)      w_next = S_GAP1;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_GAP1: w_next = S_RUN_M2;
      S_RUN_M2: begin
        w_req_addr = M2_address;
        w_req_wd   = M2_write_data;
        w_req_we_n = M2_we_n;
        if (M2_done)        w_next = S_GAP2;
        else if (w_timeout) w_next = S_ERROR;
      end
      S_GAP2: w_next = S_RUN_M1;
      S_RUN_M1: begin
        w_req_addr = M1_address;
        w_req_wd   = M1_write_data;
        w_req_we_n = M1_we_n;
        if (M1_done)        w_next = S_DONE;
        else if (w_timeout) w_next = S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_to        <= '0;
      r_sram_addr <= 18'd0;
      r_sram_wd   <= 16'd0;
      r_sram_we_n <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_hold) begin
        r_to        <= r_to + TO_W'(1);
        r_sram_addr <= w_req_addr;
        r_sram_wd   <= w_req_wd;
        r_sram_we_n <= w_req_we_n;
      end else begin
        r_to        <= '0;
        r_sram_addr <= 18'd0;
        r_sram_wd   <= 16'd0;
        r_sram_we_n <= 1'b1;
      end
    end
  end

  assign UART_enable     = w_act[0];
  assign M2_enable       = w_act[1];
  assign M1_enable       = w_act[2];
  assign SRAM_address    = r_sram_addr;
  assign SRAM_write_data = r_sram_wd;
  assign SRAM_we_n       = r_sram_we_n;
  assign Busy            = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
  assign Done            = (r_state == S_DONE);
  assign Error           = (r_state == S_ERROR);
  assign Phase           = w_act[2] ? 2'd3 : w_act[1] ? 2'd2 : w_act[0] ? 2'd1 : 2'd0;

`ifdef PHASE_PERF_EN
  logic [31:0] r_cyc [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    always_ff @(posedge Clock) begin
      if (Reset || w_start_ok) r_cyc[gi] <= 32'd0;
      else if (w_act[gi] && r_cyc[gi] != 32'hFFFF_FFFF) r_cyc[gi] <= r_cyc[gi] + 32'd1;
    end
  end

  assign UART_cycles = r_cyc[0];
  assign M2_cycles   = r_cyc[1];
  assign M1_cycles   = r_cyc[2];
`endif

endmodule

// File: tb/tb_sram_phase_scheduler.sv
// Directed bench: instance 0 default build, instance 1 short timeout, instance 2 skips UART.
module tb_sram_phase_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, start, udone, m2done, m1done;
  logic [17:0] ua, m2a, m1a;
  logic [15:0] uw, m2w, m1w;
  logic        uwe, m2we, m1we;

  logic [2:0]  uen, m2en, m1en, swe, busy, done, err;
  logic [17:0] sa  [3];
  logic [15:0] swd [3];
  logic [1:0]  ph  [3];
`ifdef PHASE_PERF_EN
  logic [31:0] ucyc [3];
  logic [31:0] m2cyc [3];
  logic [31:0] m1cyc [3];
`endif

  int checks = 0;
  int errors = 0;
  bit uart_seen_skip = 1'b0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sram_phase_scheduler #(
      .SKIP_UART     ((gi == 2) ? 1 : 0),
      .TIMEOUT_CYCLES((gi == 1) ? 16 : 4194304),
      .TO_W          ((gi == 1) ? 5 : 23)
    ) dut (
      .Clock(clk), .Reset(rst[gi]), .Start(start[gi]),
      .UART_address(ua), .UART_write_data(uw), .UART_we_n(uwe),
      .M2_address(m2a), .M2_write_data(m2w), .M2_we_n(m2we),
      .M1_address(m1a), .M1_write_data(m1w), .M1_we_n(m1we),
      .UART_done(udone[gi]), .M2_done(m2done[gi]), .M1_done(m1done[gi]),
      .UART_enable(uen[gi]), .M2_enable(m2en[gi]), .M1_enable(m1en[gi]),
      .SRAM_address(sa[gi]), .SRAM_write_data(swd[gi]), .SRAM_we_n(swe[gi]),
      .Busy(busy[gi]), .Done(done[gi]), .Error(err[gi]), .Phase(ph[gi])
`ifdef PHASE_PERF_EN
      , .UART_cycles(ucyc[gi]), .M2_cycles(m2cyc[gi]), .M1_cycles(m1cyc[gi])
`endif
    );
  end

  always @(negedge clk) if (uen[2]) uart_seen_skip = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 3'b111; start = '0; udone = '0; m2done = '0; m1done = '0;
    ua = 18'h00011; uw = 16'h1111; uwe = 1'b0;
    m2a = 18'h00022; m2w = 16'h2222; m2we = 1'b0;
    m1a = 18'h00033; m1w = 16'h3333; m1we = 1'b1;
    tick(); tick();
    rst = '0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ph[d], busy[d], done[d], err[d], swe[d], uen[d], m2en[d], m1en[d]} !== 10'b00_0001000) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d got ph=%0d busy=%b done=%b err=%b we_n=%b en=%b%b%b exp ph=0 we_n=1 rest 0",
                 d, ph[d], busy[d], done[d], err[d], swe[d], uen[d], m2en[d], m1en[d]);
      end
      checks++;
      if (sa[d] !== 18'd0 || swd[d] !== 16'd0) begin
        errors++; $display("FAIL reset_sram dut%0d got addr=%h data=%h exp 0", d, sa[d], swd[d]);
      end
    end
    $display("test_reset complete");
  endtask

  // Run one phase on dut0 for n cycles, expecting phase p; dones for other clients pulsed mid-phase.
  task automatic run_phase0(input int n, input logic [1:0] p);
    for (int i = 1; i <= n; i++) begin
      checks++;
      if (ph[0] !== p || busy[0] !== 1'b1) begin
        errors++; $display("FAIL full_phase%0d cyc %0d got ph=%0d busy=%b exp ph=%0d busy=1", p, i, ph[0], busy[0], p);
      end
      udone[0] = (p == 2'd1) ? (i == n) : (i == 3);
      m2done[0] = (p == 2'd2) ? (i == n) : (i == 3);
      m1done[0] = (p == 2'd3) ? (i == n) : (i == 3);
      tick();
    end
    udone[0] = 1'b0; m2done[0] = 1'b0; m1done[0] = 1'b0;
  endtask

  task automatic check_gap0(input string nm);
    checks++;
    if (ph[0] !== 2'd0 || swe[0] !== 1'b1 || sa[0] !== 18'd0 || {uen[0], m2en[0], m1en[0]} !== 3'b000 || busy[0] !== 1'b1) begin
      errors++; $display("FAIL %s got ph=%0d we_n=%b addr=%h en=%b%b%b busy=%b exp ph=0 we_n=1 addr=0 en=000 busy=1",
                         nm, ph[0], swe[0], sa[0], uen[0], m2en[0], m1en[0], busy[0]);
    end
  endtask

  task automatic test_full_run();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    run_phase0(10, 2'd1);
    check_gap0("gap1");
    tick();
    run_phase0(20, 2'd2);
    check_gap0("gap2");
    tick();
    run_phase0(30, 2'd3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (done[0] !== 1'b1 || busy[0] !== 1'b0 || ph[0] !== 2'd0 || swe[0] !== 1'b1) begin
        errors++; $display("FAIL done_state hold %0d got done=%b busy=%b ph=%0d we_n=%b exp 1 0 0 1", k, done[0], busy[0], ph[0], swe[0]);
      end
      tick();
    end
`ifdef PHASE_PERF_EN
    checks++;
    if (ucyc[0] !== 32'd10 || m2cyc[0] !== 32'd20 || m1cyc[0] !== 32'd30) begin
      errors++; $display("FAIL perf_counts got %0d %0d %0d exp 10 20 30", ucyc[0], m2cyc[0], m1cyc[0]);
    end
`endif
    $display("test_full_run complete");
  endtask

  task automatic test_mux_and_reset();
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    checks++;
    if (ph[0] !== 2'd1 || done[0] !== 1'b0) begin
      errors++; $display("FAIL restart_from_done got ph=%0d done=%b exp ph=1 done=0", ph[0], done[0]);
    end
    udone[0] = 1'b1; tick(); udone[0] = 1'b0;
    check_gap0("one_cycle_uart_gap");
    tick();
    m2done[0] = 1'b1; tick(); m2done[0] = 1'b0;
    tick();
    checks++;
    if (ph[0] !== 2'd3 || swe[0] !== 1'b1) begin
      errors++; $display("FAIL m1_entry got ph=%0d we_n=%b exp ph=3 we_n=1", ph[0], swe[0]);
    end
    m1a = 18'h23E00; m1w = 16'hABCD; m1we = 1'b0;
    tick();
    checks++;
    if (sa[0] !== 18'h23E00 || swd[0] !== 16'hABCD || swe[0] !== 1'b0) begin
      errors++; $display("FAIL mux_m1 got %h/%h/%b exp 23e00/abcd/0", sa[0], swd[0], swe[0]);
    end
    ua = 18'h3FFFF; uw = 16'hFFFF; uwe = 1'b1; m2a = 18'h15555; m2w = 16'h5555; m2we = 1'b1;
    tick();
    checks++;
    if (sa[0] !== 18'h23E00 || swd[0] !== 16'hABCD || swe[0] !== 1'b0) begin
      errors++; $display("FAIL mux_isolation got %h/%h/%b exp 23e00/abcd/0", sa[0], swd[0], swe[0]);
    end
    m1a = 18'h00101; m1w = 16'h0F0F;
    tick();
    checks++;
    if (sa[0] !== 18'h00101 || swd[0] !== 16'h0F0F || swe[0] !== 1'b0) begin
      errors++; $display("FAIL mux_follow got %h/%h/%b exp 00101/0f0f/0", sa[0], swd[0], swe[0]);
    end
    rst[0] = 1'b1; tick(); rst[0] = 1'b0;
    checks++;
    if (ph[0] !== 2'd0 || swe[0] !== 1'b1 || m1en[0] !== 1'b0 || busy[0] !== 1'b0 || sa[0] !== 18'd0) begin
      errors++; $display("FAIL reset_mid_write got ph=%0d we_n=%b m1en=%b busy=%b addr=%h exp 0 1 0 0 0",
                         ph[0], swe[0], m1en[0], busy[0], sa[0]);
    end
    m1we = 1'b1;
    $display("test_mux_and_reset complete");
  endtask

  task automatic test_timeout_and_busy_start();
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    udone[1] = 1'b1; tick(); udone[1] = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (ph[1] !== 2'd2 || err[1] !== 1'b0) begin
        errors++; $display("FAIL timeout_run k=%0d got ph=%0d err=%b exp ph=2 err=0", k, ph[1], err[1]);
      end
      start[1] = (k == 5);
      tick();
    end
    start[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (err[1] !== 1'b1 || m2en[1] !== 1'b0 || swe[1] !== 1'b1 || busy[1] !== 1'b0 || ph[1] !== 2'd0) begin
        errors++; $display("FAIL timeout_error hold %0d got err=%b m2en=%b we_n=%b busy=%b ph=%0d exp 1 0 1 0 0",
                           k, err[1], m2en[1], swe[1], busy[1], ph[1]);
      end
      tick();
    end
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    checks++;
    if (ph[1] !== 2'd1 || err[1] !== 1'b0 || uen[1] !== 1'b1) begin
      errors++; $display("FAIL error_restart got ph=%0d err=%b uen=%b exp 1 0 1", ph[1], err[1], uen[1]);
    end
    $display("test_timeout_and_busy_start complete");
  endtask

  task automatic test_done_vs_timeout();
    udone[1] = 1'b1; tick(); udone[1] = 1'b0;
    tick();
    m2done[1] = 1'b1; tick(); m2done[1] = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      m1done[1] = (k == 15);
      tick();
    end
    m1done[1] = 1'b0;
    checks++;
    if (done[1] !== 1'b1 || err[1] !== 1'b0) begin
      errors++; $display("FAIL done_beats_timeout got done=%b err=%b exp done=1 err=0", done[1], err[1]);
    end
    $display("test_done_vs_timeout complete");
  endtask

  task automatic test_skip_uart();
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    checks++;
    if (ph[2] !== 2'd2 || m2en[2] !== 1'b1 || uen[2] !== 1'b0) begin
      errors++; $display("FAIL skip_entry got ph=%0d m2en=%b uen=%b exp 2 1 0", ph[2], m2en[2], uen[2]);
    end
    m2done[2] = 1'b1; tick(); m2done[2] = 1'b0;
    tick();
    m1done[2] = 1'b1; tick(); m1done[2] = 1'b0;
    checks++;
    if (done[2] !== 1'b1) begin
      errors++; $display("FAIL skip_done got done=%b exp 1", done[2]);
    end
    start[2] = 1'b1; tick(); start[2] = 1'b0;
    checks++;
    if (ph[2] !== 2'd2) begin
      errors++; $display("FAIL skip_restart got ph=%0d exp 2", ph[2]);
    end
    tick();
    checks++;
    if (uart_seen_skip !== 1'b0) begin
      errors++; $display("FAIL skip_uart_enable got seen=%b exp 0", uart_seen_skip);
    end
    $display("test_skip_uart complete");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_mux_and_reset();
    test_timeout_and_busy_start();
    test_done_vs_timeout();
    test_skip_uart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
